// File: rtl/face_detect_mac_pkg.sv
`default_nettype none
// ============================================================================
// Module      : face_detect_mac_pkg
// Description : Shared constants, helper function and sideband type for the
//               face-detect multiply-accumulate pipeline.
// Revision    : 1.0 - initial parametrised release
// ============================================================================
package face_detect_mac_pkg;

  // Shallowest pipeline that still has separate operand, product and
  // output registers.
  localparam int MIN_STAGE = 3;

  // Width of the full, unclipped product of an a_w x b_w multiply.
  function automatic int ext_prod_w(input int a_w, input int b_w);
    return a_w + b_w;
  endfunction

  // Control bits that travel alongside the operands/product.
  typedef struct packed {
    logic valid;
    logic acc;
    logic last;
  } side_t;

endpackage
`default_nettype wire

// File: rtl/face_detect_mac_mul_pipe.sv
`default_nettype none
// ============================================================================
// Module      : face_detect_mac_mul_pipe
// Description : Pipelined a x b multiplier of DEPTH registers (operand stage,
//               product stage, then DEPTH-2 delay stages). Operands are
//               sign- or zero-extended to the full product width before the
//               multiply, so mixed signedness needs no special casing.
// Revision    : 1.0 - initial parametrised release
// ============================================================================
module face_detect_mac_mul_pipe
  import face_detect_mac_pkg::*;
#(
  parameter int A_W      = 16,
  parameter int B_W      = 7,
  parameter int DEPTH    = 3,
  parameter int A_SIGNED = 0,
  parameter int B_SIGNED = 0
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          ce,
  input  logic [A_W-1:0]                a,
  input  logic [B_W-1:0]                b,
  output logic [ext_prod_w(A_W,B_W)-1:0] p
);

  localparam int c_prod_w = ext_prod_w(A_W, B_W);
  localparam int c_dly    = DEPTH - 1;

  logic [A_W-1:0]      r_a;
  logic [B_W-1:0]      r_b;
  logic [c_prod_w-1:0] w_a_ext;
  logic [c_prod_w-1:0] w_b_ext;
  logic [c_prod_w-1:0] w_prod;
  logic [c_prod_w-1:0] r_p [c_dly];

  assign w_a_ext = {{B_W{(A_SIGNED != 0) & r_a[A_W-1]}}, r_a};
  assign w_b_ext = {{A_W{(B_SIGNED != 0) & r_b[B_W-1]}}, r_b};
  assign w_prod  = w_a_ext * w_b_ext;

  // Operand register, product register and delay line, all gated by ce.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_a <= '0;
      r_b <= '0;
      for (int i = 0; i < c_dly; i++) r_p[i] <= '0;
    end else if (ce) begin
      r_a    <= a;
      r_b    <= b;
      r_p[0] <= w_prod;
      for (int i = 1; i < c_dly; i++) r_p[i] <= r_p[i-1];
    end
  end

  assign p = r_p[c_dly-1];

endmodule
`default_nettype wire

// File: rtl/face_detect_mac_pipe.sv
`default_nettype none
// ============================================================================
// Module      : face_detect_mac_pipe
// Description : Pipelined multiply-accumulate with valid/ready handshake.
//               Emits the per-beat product and a running per-window sum that
//               restarts on in_acc = 0 or on the beat after in_last.
//               Optional macro FACE_DETECT_MAC_SAT_EN: saturating accumulate
//               plus a sticky per-window out_sat flag.
// Revision    : 1.0 - initial parametrised release
// ============================================================================
module face_detect_mac_pipe
  import face_detect_mac_pkg::*;
#(
  parameter int A_W       = 16,
  parameter int B_W       = 7,
  parameter int P_W       = 22,
  parameter int ACC_W     = 32,
  parameter int NUM_STAGE = 4,
  parameter int A_SIGNED  = 0,
  parameter int B_SIGNED  = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [A_W-1:0]   in_a,
  input  logic [B_W-1:0]   in_b,
  input  logic             in_acc,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [P_W-1:0]   out_prod,
  output logic [ACC_W-1:0] out_acc,
  output logic             out_last,
  output logic             busy
`ifdef FACE_DETECT_MAC_SAT_EN
  ,
  output logic             out_sat
`endif
);

  localparam int c_stage  = (NUM_STAGE < MIN_STAGE) ? MIN_STAGE : NUM_STAGE;
  localparam int c_side_n = c_stage - 1;
  localparam int c_prod_w = ext_prod_w(A_W, B_W);
  localparam bit c_signed = (A_SIGNED != 0) || (B_SIGNED != 0);

  logic                w_adv;
  side_t               r_side [c_side_n];
  side_t               w_tail;
  logic [c_prod_w-1:0] w_prod_full;
  logic [P_W-1:0]      w_prod_p;
  logic [ACC_W-1:0]    w_prod_acc;
  logic [ACC_W-1:0]    w_base;
  logic [ACC_W-1:0]    w_next;
  logic                w_new;
  logic                r_out_valid;
  logic                r_out_last;
  logic [P_W-1:0]      r_out_prod;
  logic [ACC_W-1:0]    r_run;
  logic                r_clr_pending;

  // Whole pipeline freezes only when the output holds an unconsumed beat.
  assign w_adv    = ~(r_out_valid & ~out_ready);
  assign in_ready = w_adv & ~reset;
  assign w_tail   = r_side[c_side_n-1];

  face_detect_mac_mul_pipe #(
    .A_W      (A_W),
    .B_W      (B_W),
    .DEPTH    (c_stage - 1),
    .A_SIGNED (A_SIGNED),
    .B_SIGNED (B_SIGNED)
  ) u_mul (
    .clk   (clk),
    .reset (reset),
    .ce    (w_adv),
    .a     (in_a),
    .b     (in_b),
    .p     (w_prod_full)
  );

  // Product resized to P_W: truncate, pass through, or extend.
  generate
    if (P_W < c_prod_w) begin : g_pext_trunc
      logic w_unused_prod_hi;
      assign w_unused_prod_hi = ^w_prod_full[c_prod_w-1:P_W];
      assign w_prod_p         = w_prod_full[P_W-1:0];
    end else if (P_W == c_prod_w) begin : g_pext_same
      assign w_prod_p = w_prod_full;
    end else begin : g_pext_wide
      assign w_prod_p = {{(P_W-c_prod_w){c_signed & w_prod_full[c_prod_w-1]}}, w_prod_full};
    end
  endgenerate

  // Product extended to the accumulator width.
  generate
    if (ACC_W > P_W) begin : g_aext_wide
      assign w_prod_acc = {{(ACC_W-P_W){c_signed & w_prod_p[P_W-1]}}, w_prod_p};
    end else begin : g_aext_same
      assign w_prod_acc = w_prod_p;
    end
  endgenerate

  assign w_new  = ~w_tail.acc | r_clr_pending;
  assign w_base = w_new ? '0 : r_run;

`ifdef FACE_DETECT_MAC_SAT_EN
  logic [ACC_W:0] w_sum_x;
  logic           w_clip;
  logic           r_sat;

  // Saturating add: signed overflow clamps to max/min, unsigned carry to max.
  always_comb begin
    w_sum_x = {1'b0, w_base} + {1'b0, w_prod_acc};
    w_next  = w_sum_x[ACC_W-1:0];
    w_clip  = 1'b0;
    if (c_signed) begin
      if ((w_base[ACC_W-1] == w_prod_acc[ACC_W-1]) && (w_next[ACC_W-1] != w_base[ACC_W-1])) begin
        w_clip = 1'b1;
        w_next = w_base[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
      end
    end else if (w_sum_x[ACC_W]) begin
      w_clip = 1'b1;
      w_next = '1;
    end
  end

  // Sticky clip flag, restarted together with the running sum.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sat <= 1'b0;
    end else if (w_adv && w_tail.valid) begin
      r_sat <= (r_sat & ~w_new) | w_clip;
    end
  end

  assign out_sat = r_sat;
`else
  assign w_next = w_base + w_prod_acc;
`endif

  // Sideband shift register kept in lock-step with the multiplier stages.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < c_side_n; i++) r_side[i] <= '0;
    end else if (w_adv) begin
      r_side[0] <= side_t'{valid: in_valid, acc: in_acc, last: in_last};
      for (int i = 1; i < c_side_n; i++) r_side[i] <= r_side[i-1];
    end
  end

  // Output stage; the running sum doubles as out_acc since both update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_valid   <= 1'b0;
      r_out_last    <= 1'b0;
      r_out_prod    <= '0;
      r_run         <= '0;
      r_clr_pending <= 1'b0;
    end else if (w_adv) begin
      r_out_valid <= w_tail.valid;
      r_out_last  <= w_tail.valid & w_tail.last;
      if (w_tail.valid) begin
        r_out_prod    <= w_prod_p;
        r_run         <= w_next;
        r_clr_pending <= w_tail.last;
      end
    end
  end

  // Busy while any stage, including the output, holds a beat.
  always_comb begin
    busy = r_out_valid;
    for (int i = 0; i < c_side_n; i++) busy = busy | r_side[i].valid;
  end

  assign out_valid = r_out_valid;
  assign out_last  = r_out_last;
  assign out_prod  = r_out_prod;
  assign out_acc   = r_run;

endmodule
`default_nettype wire

// File: tb/tb_face_detect_mac_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_face_detect_mac_pipe
// Description : Self-checking bench: queue-based reference model for the
//               default configuration plus literal checks, a signed instance
//               and (with FACE_DETECT_MAC_SAT_EN) a saturating instance.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_face_detect_mac_pipe;

  localparam int NS = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, in_valid, in_acc, in_last, out_ready;
  logic [15:0] in_a;
  logic [6:0]  in_b;
  logic        in_ready, out_valid, out_last, busy;
  logic [21:0] out_prod;
  logic [31:0] out_acc;

  logic        s_valid, s_acc, s_last, s_in_ready, s_out_valid, s_out_last, s_busy;
  logic [15:0] s_a;
  logic [6:0]  s_b;
  logic [21:0] s_out_prod;
  logic [31:0] s_out_acc;

`ifdef FACE_DETECT_MAC_SAT_EN
  logic        out_sat, s_out_sat;
  logic        x_valid, x_acc, x_last, x_in_ready, x_out_valid, x_out_last, x_busy, x_out_sat;
  logic [15:0] x_a;
  logic [6:0]  x_b;
  logic [21:0] x_out_prod, x_out_acc;
`endif

  face_detect_mac_pipe dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_acc(in_acc), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_prod(out_prod),
    .out_acc(out_acc), .out_last(out_last), .busy(busy)
`ifdef FACE_DETECT_MAC_SAT_EN
    , .out_sat(out_sat)
`endif
  );

  face_detect_mac_pipe #(.A_SIGNED(1), .B_SIGNED(1)) dut_s (
    .clk(clk), .reset(reset), .in_valid(s_valid), .in_ready(s_in_ready),
    .in_a(s_a), .in_b(s_b), .in_acc(s_acc), .in_last(s_last),
    .out_valid(s_out_valid), .out_ready(1'b1), .out_prod(s_out_prod),
    .out_acc(s_out_acc), .out_last(s_out_last), .busy(s_busy)
`ifdef FACE_DETECT_MAC_SAT_EN
    , .out_sat(s_out_sat)
`endif
  );

`ifdef FACE_DETECT_MAC_SAT_EN
  face_detect_mac_pipe #(.ACC_W(22)) dut_x (
    .clk(clk), .reset(reset), .in_valid(x_valid), .in_ready(x_in_ready),
    .in_a(x_a), .in_b(x_b), .in_acc(x_acc), .in_last(x_last),
    .out_valid(x_out_valid), .out_ready(1'b1), .out_prod(x_out_prod),
    .out_acc(x_out_acc), .out_last(x_out_last), .busy(x_busy), .out_sat(x_out_sat)
  );
  logic [21:0] x_log_acc[$];
  bit          x_log_sat[$];
  always @(negedge clk) if (x_out_valid) begin
    x_log_acc.push_back(x_out_acc);
    x_log_sat.push_back(x_out_sat);
  end
`endif

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [21:0] prod;
    logic [31:0] acc;
    bit          last;
    bit          sat;
    int          cyc;
  } exp_t;

  exp_t        q[$];
  logic [21:0] obs_prod[$];
  logic [31:0] obs_acc[$];
  bit          obs_last[$];
  longint      m_run, m_p, m_sum;
  bit          m_clr, m_sat, m_new, prev_stall, lat_chk;
  int          cyc;
  exp_t        e;

  initial begin
    m_run = 0; m_clr = 0; m_sat = 0; prev_stall = 0; lat_chk = 0; cyc = 0;
  end

  // Compare process: all checks happen on the falling edge.
  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      check("in_ready_in_reset", in_ready, 0);
      q.delete();
      m_run = 0; m_clr = 0; m_sat = 0; prev_stall = 0;
    end else begin
      check("in_ready", in_ready, !(out_valid && !out_ready));
      check("busy", busy, q.size() != 0);
      if (prev_stall) check("hold_valid", out_valid, 1);
      if (out_valid) begin
        if (q.size() == 0) begin
          check("spurious_out", out_valid, 0);
        end else begin
          e = q[0];
          check("prod", out_prod, e.prod);
          check("acc", out_acc, e.acc);
          check("last", out_last, e.last);
`ifdef FACE_DETECT_MAC_SAT_EN
          check("sat", out_sat, e.sat);
`endif
          if (lat_chk) check("latency", cyc - e.cyc, NS);
          if (out_ready) begin
            void'(q.pop_front());
            obs_prod.push_back(out_prod);
            obs_acc.push_back(out_acc);
            obs_last.push_back(out_last);
          end
        end
      end
      prev_stall = out_valid && !out_ready;
      if (in_valid && in_ready) begin
        m_p   = (longint'(in_a) * longint'(in_b)) & 64'h3F_FFFF;
        m_new = !in_acc || m_clr;
        m_sum = (m_new ? 64'd0 : m_run) + m_p;
`ifdef FACE_DETECT_MAC_SAT_EN
        if (m_new) m_sat = 0;
        if (m_sum > 64'hFFFF_FFFF) begin
          m_sum = 64'hFFFF_FFFF;
          m_sat = 1;
        end
`else
        m_sum = m_sum & 64'hFFFF_FFFF;
`endif
        m_run  = m_sum;
        m_clr  = in_last;
        e.prod = m_p[21:0];
        e.acc  = m_sum[31:0];
        e.last = in_last;
        e.sat  = m_sat;
        e.cyc  = cyc;
        q.push_back(e);
      end
    end
  end

  logic [21:0] s_log_prod[$];
  logic [31:0] s_log_acc[$];
  always @(negedge clk) if (s_out_valid) begin
    s_log_prod.push_back(s_out_prod);
    s_log_acc.push_back(s_out_acc);
  end

  // Present one beat and hold it until accepted (bounded).
  task automatic send(input logic [15:0] a, input logic [6:0] b, input bit acc, input bit last);
    int n;
    n = 0;
    in_valid = 1; in_a = a; in_b = b; in_acc = acc; in_last = last;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 50);
    check("send_accept", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 0;
  endtask

  int base, j, n;

  initial begin
    reset = 1; in_valid = 0; in_a = 0; in_b = 0; in_acc = 0; in_last = 0; out_ready = 1;
    s_valid = 0; s_a = 0; s_b = 0; s_acc = 0; s_last = 0;
`ifdef FACE_DETECT_MAC_SAT_EN
    x_valid = 0; x_a = 0; x_b = 0; x_acc = 0; x_last = 0;
`endif
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_out_prod", out_prod, 0);
    check("rst_out_acc", out_acc, 0);
    check("rst_out_last", out_last, 0);
    reset = 0;

    // Window of three beats, then an in_acc=1 beat straight after last.
    lat_chk = 1;
    base = obs_prod.size();
    send(16'd100, 7'd3, 0, 0);
    send(16'd200, 7'd5, 1, 0);
    send(16'd7, 7'd127, 1, 1);
    send(16'd10, 7'd2, 1, 0);
    repeat (8) @(posedge clk);
    #1;
    lat_chk = 0;
    check("t1_count", obs_prod.size() - base, 4);
    if (obs_prod.size() >= base + 4) begin
      check("t1_prod0", obs_prod[base], 300);
      check("t1_prod1", obs_prod[base+1], 1000);
      check("t1_prod2", obs_prod[base+2], 889);
      check("t1_acc0", obs_acc[base], 300);
      check("t1_acc1", obs_acc[base+1], 1300);
      check("t1_acc2", obs_acc[base+2], 2189);
      check("t1_last1", obs_last[base+1], 0);
      check("t1_last2", obs_last[base+2], 1);
      check("t2_acc_after_last", obs_acc[base+3], 20);
    end

    // Signed operands.
    s_valid = 1; s_a = 16'hFFFB; s_b = 7'h7D; s_acc = 0;
    @(posedge clk); #1;
    s_b = 7'h03;
    @(posedge clk); #1;
    s_valid = 0;
    repeat (8) @(posedge clk);
    #1;
    check("t3_count", s_log_prod.size(), 2);
    if (s_log_prod.size() >= 2) begin
      check("t3_prod_pos", s_log_prod[0], 15);
      check("t3_acc_pos", s_log_acc[0], 15);
      check("t3_prod_neg", s_log_prod[1], 22'h3FFFF1);
      check("t3_acc_neg", s_log_acc[1], 32'hFFFF_FFF1);
    end

    // Continuous stream with six cycles of output backpressure.
    base = obs_prod.size();
    j = 0;
    for (int i = 0; i < 16; i++) begin
      in_valid = 1; in_a = 16'(1000 + j * 37); in_b = 7'(j + 1); in_acc = 1; in_last = (j % 5 == 4);
      out_ready = !(i >= 4 && i < 10);
      @(negedge clk);
      if (in_ready) j++;
      @(posedge clk); #1;
    end
    in_valid = 0; out_ready = 1;
    repeat (10) @(posedge clk);
    #1;
    check("t4_no_loss_dup", obs_prod.size() - base, j);

    // Reset with three beats in flight.
    base = obs_prod.size();
    send(16'd5, 7'd5, 0, 0);
    send(16'd6, 7'd6, 1, 0);
    send(16'd7, 7'd7, 1, 0);
    reset = 1;
    @(posedge clk); #1;
    check("t5_busy", busy, 0);
    check("t5_out_valid", out_valid, 0);
    reset = 0;
    send(16'd1, 7'd1, 1, 0);
    repeat (8) @(posedge clk);
    #1;
    check("t5_count", obs_prod.size() - base, 1);
    if (obs_prod.size() > base) check("t5_acc", obs_acc[base], 1);

`ifdef FACE_DETECT_MAC_SAT_EN
    x_valid = 1; x_a = 16'hFFFF; x_b = 7'd127; x_acc = 0;
    @(posedge clk); #1;
    x_acc = 1;
    @(posedge clk); #1;
    x_a = 16'd1; x_b = 7'd1; x_acc = 0;
    @(posedge clk); #1;
    x_valid = 0;
    repeat (8) @(posedge clk);
    #1;
    check("t6_count", x_log_acc.size(), 3);
    if (x_log_acc.size() >= 3) begin
      check("t6_acc0", x_log_acc[0], 22'd4128641);
      check("t6_sat0", x_log_sat[0], 0);
      check("t6_acc1", x_log_acc[1], 22'h3FFFFF);
      check("t6_sat1", x_log_sat[1], 1);
      check("t6_acc2", x_log_acc[2], 1);
      check("t6_sat2", x_log_sat[2], 0);
    end
`endif

    // Randomized traffic with random backpressure and a mid-run reset.
    for (int i = 0; i < 600; i++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      in_a      = 16'($urandom);
      in_b      = 7'($urandom);
      in_acc    = ($urandom_range(0, 3) != 0);
      in_last   = ($urandom_range(0, 5) == 0);
      out_ready = ($urandom_range(0, 9) < 7);
      reset     = (i == 300 || i == 301);
      @(posedge clk); #1;
    end
    reset = 0; in_valid = 0; out_ready = 1;
    n = 0;
    while (q.size() != 0 && n < 30) begin
      @(posedge clk);
      n++;
    end
    @(posedge clk); #1;
    check("drain_empty", q.size(), 0);
    check("drain_busy", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/face_detect_mac_pipe.md
Name: face_detect_mac_pipe

Overview:
- Parametrised successor to the fixed 16x7 face-detect DSP multiplier.
- Pipelined multiply-accumulate with configurable operand, product and accumulator widths, depth and per-operand signedness.
- Uses valid/ready handshakes with backpressure.
- Sits between the integral-image/feature fetch stage and the Haar classifier-sum logic.
- Produces both the raw product and a running per-window accumulation, delimited by a last flag.

Parameters:
- A_W, 16, width of operand a
- B_W, 7, width of operand b
- P_W, 22, output product width (low P_W bits of full product; sign/zero-extended if P_W > A_W+B_W)
- ACC_W, 32, accumulator width (ACC_W >= P_W)
- NUM_STAGE, 4, total latency in advancing cycles (min 3)
- A_SIGNED, 0, 1 = treat a as two's complement
- B_SIGNED, 0, 1 = treat b as two's complement

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- in_valid  in  1  input beat valid
- in_ready  out  1  block can accept beat
- in_a  in  A_W  multiplicand
- in_b  in  B_W  multiplier
- in_acc  in  1  1 = add to running sum, 0 = start new sum with this product
- in_last  in  1  final beat of window
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts
- out_prod  out  P_W  product of this beat
- out_acc  out  ACC_W  running sum including this beat
- out_last  out  1  in_last delayed with beat
- busy  out  1  any valid beat in pipeline

Behaviour:
- Clock and reset: one clock, clk; reset synchronous, active-high.
- Reset: all stage valid bits, out_valid, out_last and busy go to 0; out_prod, out_acc and the running accumulator go to 0; the clear-pending flag goes to 0.
  - in_ready = 0 while reset is high; beats presented during reset are dropped.
- Stall: stall = out_valid & ~out_ready; adv = ~stall.
  - in_ready = adv (combinational, no input register bypass).
  - Beat accepted when in_valid & in_ready.
- Pipeline:
  - Stage 1 registers a, b, acc, last and valid.
  - Stage 2 registers the full (A_W+B_W)-bit product.
  - NUM_STAGE-3 further delay registers follow.
  - The output stage is the final register.
  - All stages move only when adv is high; bubbles do not collapse.
  - Latency is exactly NUM_STAGE advancing cycles: accept at cycle 0 -> out_valid at cycle NUM_STAGE when never stalled.
  - Throughput is 1 beat/cycle.
- Arithmetic:
  - Each operand is sign- or zero-extended per A_SIGNED/B_SIGNED.
  - Product is signed if either operand is signed.
  - out_prod = low P_W bits, extended if wider.
- Accumulator, updated on load into the output stage:
  - base = (acc_bit & ~clr_pending) ? run : 0
  - run <= base + ext(prod), wrapping modulo 2^ACC_W.
  - out_acc <= same value.
  - clr_pending <= last bit of the loaded beat.
  - Bubbles loaded into the output stage leave run and clr_pending unchanged.
- Output hold: while stalled, out_prod, out_acc and out_last stay stable and out_valid stays high.
- busy = OR of all stage valid bits including out_valid.
- Reset mid-operation flushes every in-flight beat and the running sum; no output appears for those beats.

Optional Feature:
- Macro: FACE_DETECT_MAC_SAT_EN.
- When defined:
  - Accumulator addition saturates to the ACC_W max/min, signed if either operand is signed, otherwise unsigned max.
  - Extra port out_sat (out, 1): set when any add in the current window clipped; cleared on a new sum (in_acc = 0 or after last).
- When undefined: wrap-around arithmetic; out_sat is absent.

Decomposition:
- Package face_detect_mac_pkg:
  - MIN_STAGE = 3.
  - Function for extended product width.
  - Typedef for the stage sideband struct {valid, acc, last}.
- Sub-module face_detect_mac_mul_pipe:
  - Ports: clk, reset, ce, a, b, p.
  - Parametrised pipelined multiplier of depth NUM_STAGE-1, DSP-inferable.
- Top module adds the sideband shift register, handshake and accumulator.

Test Plan:
1. Defaults, out_ready = 1, beats (100,3), (200,5), (7,127) with in_acc = 0,1,1 and last on the third -> out_prod 300, 1000, 889; out_acc 300, 1300, 2189; out_last on the third; each out_valid exactly 4 cycles after accept.
2. Next beat (10,2) with in_acc = 1 immediately after last -> out_acc = 20 (clear after last).
3. A_SIGNED = 1, B_SIGNED = 1: a = -5 (0xFFFB), b = -3 (0x7D) -> out_prod = 15; a = -5, b = 3 -> out_prod sign-extended -15 (0x3FFFF1).
4. Hold out_ready = 0 for 6 cycles with a continuous input stream -> in_ready drops the cycle after out_valid rises; no beat lost or duplicated; outputs stable; order preserved after release.
5. Assert reset with 3 beats in flight -> busy = 0, out_valid = 0 next cycle; post-reset beat (1,1), in_acc = 1 -> out_acc = 1.
6. FACE_DETECT_MAC_SAT_EN, ACC_W = 22: accumulate 65535*127 twice -> out_acc = 0x3FFFFF, out_sat = 1; next in_acc = 0 beat -> out_sat = 0.
